// File: rtl/dm_arbiter.sv
// CPU/DMA arbiter onto one data memory port (IDLE -> ACCESS -> DONE per access).
// Define DM_ARB_RR_EN for round-robin arbitration; default is fixed priority (m0 wins).
module dm_arbiter #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        dm_we,
   output logic [31:0] dm_a,
   output logic [31:0] dm_wd,
   input  logic [31:0] dm_rd,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t      state;
   logic        owner;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rd_q;
   logic        idle;
   logic        in_range;
   logic        gnt0;
   logic        gnt1;

   assign idle     = reset && (state == IDLE);
   assign in_range = addr_q < ADDR_LIMIT;

`ifdef DM_ARB_RR_EN
   logic last_owner;

   // On contention the port that did not win last time gets the bus.
   assign gnt0 = idle && m0_req && (!m1_req || last_owner);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_owner <= 1'b1;
      end else if (gnt0 || gnt1) begin
         last_owner <= gnt1;
      end
   end
`else
   assign gnt0 = idle && m0_req;
`endif

   assign gnt1 = idle && m1_req && !gnt0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         owner   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  state   <= ACCESS;
                  owner   <= gnt1;
                  we_q    <= gnt1 ? m1_we : m0_we;
                  addr_q  <= gnt1 ? m1_addr : m0_addr;
                  wdata_q <= gnt1 ? m1_wdata : m0_wdata;
               end
            end
            ACCESS: begin
               state <= DONE;
               rd_q  <= in_range ? dm_rd : '0;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   logic        acc;
   logic        done;
   logic [31:0] rdata;

   assign acc   = state == ACCESS;
   assign done  = state == DONE;
   assign rdata = we_q ? '0 : rd_q;

   assign m0_gnt    = gnt0;
   assign m1_gnt    = gnt1;
   assign busy      = state != IDLE;

   assign dm_we     = acc && we_q && in_range;
   assign dm_a      = acc ? addr_q : '0;
   assign dm_wd     = acc ? wdata_q : '0;

   assign m0_rvalid = done && !owner;
   assign m1_rvalid = done && owner;
   assign m0_rdata  = m0_rvalid ? rdata : '0;
   assign m1_rdata  = m1_rvalid ? rdata : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized + directed bench for dm_arbiter against a transaction-level model.
// Build with or without DM_ARB_RR_EN; the model follows the same macro.
module tb_dm_arbiter;

   localparam logic [31:0] LIMIT = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        dm_we, busy;
   logic [31:0] dm_a, dm_wd, dm_rd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dm_arbiter #(.ADDR_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m1_rdata(m1_rdata),
      .dm_we(dm_we), .dm_a(dm_a), .dm_wd(dm_wd), .dm_rd(dm_rd),
      .busy(busy)
   );

   // Physical memory behind the DUT
   logic [31:0] mem [0:1023];
   initial for (int i = 0; i < 1024; i++) mem[i] = '0;
   always @(posedge clk) if (dm_we) mem[dm_a[11:2]] <= dm_wd;
   assign dm_rd = mem[dm_a[11:2]];

   // Transaction-level reference state
   logic [31:0] refmem [int];
   int          mphase = 0;
   int          mown = 0;
   int          last = 1;
   logic        mwe;
   logic [31:0] maddr, mwd, edata;
   bit          g0f, g1f;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_rd(logic [31:0] a);
      if (a >= LIMIT) return '0;
      if (refmem.exists(int'(a >> 2))) return refmem[int'(a >> 2)];
      return '0;
   endfunction

   task automatic set_req(int m, logic we, logic [31:0] a, logic [31:0] d);
      if (m == 0) begin
         m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
      end else begin
         m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
      end
   endtask

   // Called just after a negedge with inputs driven; ends at the next negedge.
   task automatic tick();
      logic e0, e1, inr;
      #2;
      e0 = 1'b0;
      e1 = 1'b0;
      if (mphase == 0) begin
         if (m0_req && m1_req) begin
`ifdef DM_ARB_RR_EN
            e0 = (last == 1);
`else
            e0 = 1'b1;
`endif
            e1 = !e0;
         end else begin
            e0 = m0_req;
            e1 = m1_req;
         end
      end
      inr = maddr < LIMIT;
      chk("m0_gnt", m0_gnt, e0);
      chk("m1_gnt", m1_gnt, e1);
      chk("busy", busy, mphase != 0);
      chk("dm_we", dm_we, mphase == 1 && mwe && inr);
      chk("dm_a", dm_a, mphase == 1 ? maddr : 32'h0);
      chk("dm_wd", dm_wd, mphase == 1 ? mwd : 32'h0);
      chk("m0_rvalid", m0_rvalid, mphase == 2 && mown == 0);
      chk("m1_rvalid", m1_rvalid, mphase == 2 && mown == 1);
      chk("m0_rdata", m0_rdata,
          (mphase == 2 && mown == 0) ? edata : 32'h0);
      chk("m1_rdata", m1_rdata,
          (mphase == 2 && mown == 1) ? edata : 32'h0);
      @(posedge clk);
      g0f = 1'b0;
      g1f = 1'b0;
      if (mphase == 0) begin
         if (e0 || e1) begin
            mown  = e1 ? 1 : 0;
            mwe   = e1 ? m1_we : m0_we;
            maddr = e1 ? m1_addr : m0_addr;
            mwd   = e1 ? m1_wdata : m0_wdata;
            last  = mown;
            g0f   = e0;
            g1f   = e1;
            mphase = 1;
         end
      end else if (mphase == 1) begin
         edata = mwe ? 32'h0 : ref_rd(maddr);
         if (mwe && inr) refmem[int'(maddr >> 2)] = mwd;
         mphase = 2;
      end else begin
         mphase = 0;
      end
      @(negedge clk);
      if (g0f) m0_req = 1'b0;
      if (g1f) m1_req = 1'b0;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [31:0] rnd_addr();
      if ($urandom_range(0, 9) == 0)
         return LIMIT + 32'($urandom_range(0, 15)) * 4;
      return 32'($urandom_range(0, 31)) * 4;
   endfunction

   initial begin
      reset = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      @(negedge clk);
      // Requests during reset must not be granted
      m0_req = 1'b1;
      m1_req = 1'b1;
      #2;
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dm_we", dm_we, 0);
      chk("rst_dm_a", dm_a, 0);
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m1_rvalid", m1_rvalid, 0);
      m0_req = 1'b0;
      m1_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // Write then read back through m0
      set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
      run(3);
      set_req(0, 1'b0, 32'h10, 32'h0);
      run(3);
      chk("rd_0x10_model", edata, 32'hDEADBEEF);

      // Out-of-range write/read via m1
      set_req(1, 1'b1, 32'h1000, 32'h1234);
      run(3);
      set_req(1, 1'b0, 32'h1000, 32'h0);
      run(3);

      // First contention after reset, then sustained contention
      for (int r = 0; r < 6; r++) begin
         if (!m0_req) set_req(0, 1'b0, 32'h10, 32'h0);
         if (!m1_req) set_req(1, 1'b0, 32'h14, 32'h0);
         run(3);
      end
      run(6);

      // m1 arrives while m0 is in ACCESS
      set_req(0, 1'b1, 32'h20, 32'h11112222);
      tick();
      set_req(1, 1'b0, 32'h20, 32'h0);
      run(6);

      // Reset in the middle of a write to 0x20
      set_req(0, 1'b1, 32'h20, 32'hCAFEF00D);
      tick();
      #1;
      chk("pre_rst_dm_we", dm_we, 1);
      reset = 1'b0;
      #1;
      chk("async_dm_we", dm_we, 0);
      chk("async_busy", busy, 0);
      chk("async_dm_a", dm_a, 0);
      @(negedge clk);
      reset = 1'b1;
      mphase = 0;
      last = 1;
      set_req(0, 1'b0, 32'h20, 32'h0);
      run(3);
      chk("rd_0x20_model", edata, 32'h11112222);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         if (!m0_req && $urandom_range(0, 2) == 0)
            set_req(0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
         if (!m1_req && $urandom_range(0, 2) == 0)
            set_req(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
         if (mphase != 0 && $urandom_range(0, 19) == 0) m0_req = 1'b0;
         if (mphase != 0 && $urandom_range(0, 19) == 0) m1_req = 1'b0;
         tick();
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      run(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
